// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_event_pkg
// Purpose  : Shared button FSM state encoding and Interrupt bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package button_event_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam logic [1:0] ST_RELEASED     = RELEASED;
    localparam logic [1:0] ST_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [1:0] ST_PRESSED      = PRESSED;
    localparam logic [1:0] ST_RELEASE_WAIT = RELEASE_WAIT;

    localparam int RESET_RELEASE = 0;
    localparam int RESET_PRESS   = 1;
    localparam int POWER_RELEASE = 2;
    localparam int POWER_PRESS   = 3;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Synchronises one active-low button pin and debounces it on the
//            shared tick, producing a level and one-cycle press/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button_n,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int            CW     = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_MS - 1);

    logic          sync1_q, sync2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          w_pressed;

    // Synchroniser idles high so a reset never looks like a press.
    assign w_pressed = ~sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (w_pressed) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_pressed) begin
                    state_d = ST_RELEASED;
                end else if (i_tick) begin
                    if (cnt_q == C_LAST) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PRESSED: begin
                if (!w_pressed) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_pressed) begin
                    state_d = ST_PRESSED;
                end else if (i_tick) begin
                    if (cnt_q == C_LAST) begin
                        state_d   = ST_RELEASED;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
        level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= i_button_n;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : button_event_gen
// Purpose  : Front-panel power/reset button conditioner driving the interrupt
//            controller; optional power long-press via BUTTON_LONG_PRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_gen
    import button_event_pkg::*;
#(
    parameter int TICK_DIV      = 33000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 4000
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       PowerButtonN,
    input  logic       ResetButtonN,
    output logic [3:0] Interrupt,
    output logic       PowerButtonLevel,
    output logic       ResetButtonLevel,
    output logic       PowerLongPress
);

    localparam int            PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          w_tick;
    logic          w_power_press, w_power_release;
    logic          w_reset_press, w_reset_release;

    assign w_tick  = (presc_q == C_PRESC_LAST);
    assign presc_d = w_tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    button_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_power (
        .clk        (LpcClock),
        .rst_n      (PciReset),
        .i_button_n (PowerButtonN),
        .i_tick     (w_tick),
        .o_level    (PowerButtonLevel),
        .o_press    (w_power_press),
        .o_release  (w_power_release)
    );

    button_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_reset (
        .clk        (LpcClock),
        .rst_n      (PciReset),
        .i_button_n (ResetButtonN),
        .i_tick     (w_tick),
        .o_level    (ResetButtonLevel),
        .o_press    (w_reset_press),
        .o_release  (w_reset_release)
    );

    always_comb begin
        Interrupt                = 4'b0000;
        Interrupt[POWER_PRESS]   = w_power_press;
        Interrupt[POWER_RELEASE] = w_power_release;
        Interrupt[RESET_PRESS]   = w_reset_press;
        Interrupt[RESET_RELEASE] = w_reset_release;
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int            LW       = $clog2(LONG_PRESS_MS + 1);
    localparam logic [LW-1:0] C_LP_MAX = LW'(LONG_PRESS_MS);

    logic [LW-1:0] lp_cnt_q, lp_cnt_d;
    logic          lp_pulse_q, lp_pulse_d;

    // Level low means RELEASED/PRESS_WAIT; a RELEASE_WAIT bounce keeps the count.
    always_comb begin
        lp_cnt_d   = lp_cnt_q;
        lp_pulse_d = 1'b0;
        if (!PowerButtonLevel) begin
            lp_cnt_d = '0;
        end else if (w_tick && (lp_cnt_q != C_LP_MAX)) begin
            lp_cnt_d   = lp_cnt_q + 1'b1;
            lp_pulse_d = (lp_cnt_q == (C_LP_MAX - 1'b1));
        end
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            lp_cnt_q   <= '0;
            lp_pulse_q <= 1'b0;
        end else begin
            lp_cnt_q   <= lp_cnt_d;
            lp_pulse_q <= lp_pulse_d;
        end
    end

    assign PowerLongPress = lp_pulse_q;
`else
    assign PowerLongPress = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_gen
// Purpose  : Self-checking bench for button_event_gen with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_event_gen;

    localparam int TICK_DIV      = 4;
    localparam int DEBOUNCE_MS   = 3;
    localparam int LONG_PRESS_MS = 10;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       LpcClock     = 1'b0;
    logic       PciReset     = 1'b0;
    logic       PowerButtonN = 1'b0;
    logic       ResetButtonN = 1'b0;
    logic [3:0] Interrupt;
    logic       PowerButtonLevel;
    logic       ResetButtonLevel;
    logic       PowerLongPress;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 LpcClock = ~LpcClock;

    button_event_gen #(
        .TICK_DIV      (TICK_DIV),
        .DEBOUNCE_MS   (DEBOUNCE_MS),
        .LONG_PRESS_MS (LONG_PRESS_MS)
    ) dut (
        .LpcClock         (LpcClock),
        .PciReset         (PciReset),
        .PowerButtonN     (PowerButtonN),
        .ResetButtonN     (ResetButtonN),
        .Interrupt        (Interrupt),
        .PowerButtonLevel (PowerButtonLevel),
        .ResetButtonLevel (ResetButtonLevel),
        .PowerLongPress   (PowerLongPress)
    );

    // Model: debounced level per button flips once the synchronised pin has
    // disagreed with it for DEBOUNCE_MS ticks counted after the first
    // disagreeing edge; ticks fall on every TICK_DIV-th edge after reset.
    logic [3:0] exp_int = 4'b0;
    bit         exp_lev[2];
    bit         exp_lp  = 1'b0;
    bit         m_d1[2], m_d2[2], m_pend[2];
    int         m_ticks[2];
    int         m_n  = 0;
    int         m_lp = 0;

    initial begin
        bit pin[2];
        bit s, tick, lev_old;
        int idx;
        forever begin
            @(posedge LpcClock);
            cyc++;
            pin[0]  = PowerButtonN;
            pin[1]  = ResetButtonN;
            exp_int = 4'b0;
            exp_lp  = 1'b0;
            if (!PciReset) begin
                m_n  = 0;
                m_lp = 0;
                for (int b = 0; b < 2; b++) begin
                    m_d1[b] = 1'b1; m_d2[b] = 1'b1; m_pend[b] = 1'b0;
                    m_ticks[b] = 0; exp_lev[b] = 1'b0;
                end
            end else begin
                tick = ((m_n % TICK_DIV) == TICK_DIV - 1);
                m_n++;
                lev_old = exp_lev[0];
                for (int b = 0; b < 2; b++) begin
                    s = !m_d2[b];
                    m_d2[b] = m_d1[b];
                    m_d1[b] = pin[b];
                    if (s == exp_lev[b]) begin
                        m_pend[b] = 1'b0;
                    end else if (!m_pend[b]) begin
                        m_pend[b]  = 1'b1;
                        m_ticks[b] = 0;
                    end else if (tick) begin
                        m_ticks[b]++;
                        if (m_ticks[b] == DEBOUNCE_MS) begin
                            exp_lev[b] = s;
                            m_pend[b]  = 1'b0;
                            idx = (b == 0) ? (s ? 3 : 2) : (s ? 1 : 0);
                            exp_int[idx] = 1'b1;
                        end
                    end
                end
                if (LP_EN) begin
                    if (!lev_old) begin
                        m_lp = 0;
                    end else if (tick && m_lp < LONG_PRESS_MS) begin
                        m_lp++;
                        exp_lp = (m_lp == LONG_PRESS_MS);
                    end
                end
            end
        end
    end

    // Per-cycle compare plus pulse/level bookkeeping for the directed checks.
    int pcnt[5];
    int pfirst[5];
    bit lvl_hi[2];
    bit lvl_lo[2];

    initial begin
        logic [6:0] act, exp;
        forever begin
            @(negedge LpcClock);
            act = {Interrupt, PowerButtonLevel, ResetButtonLevel, PowerLongPress};
            exp = {exp_int, exp_lev[0], exp_lev[1], exp_lp};
            compared++;
            if (act !== exp) begin
                mismatched++;
                $display("FAIL cycle_compare @%0d: got %b expected %b", cyc, act, exp);
            end
            for (int i = 0; i < 5; i++) begin
                if ((i < 4) ? Interrupt[i] : PowerLongPress) begin
                    pcnt[i]++;
                    if (pfirst[i] < 0) pfirst[i] = cyc;
                end
            end
            if (PowerButtonLevel) lvl_hi[0] = 1'b1; else lvl_lo[0] = 1'b1;
            if (ResetButtonLevel) lvl_hi[1] = 1'b1; else lvl_lo[1] = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge LpcClock);
            #1;
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 5; i++) begin
            pcnt[i]   = 0;
            pfirst[i] = -1;
        end
        for (int b = 0; b < 2; b++) begin
            lvl_hi[b] = 1'b0;
            lvl_lo[b] = 1'b0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        compared++;
        if (act < lo || act > hi) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    initial begin
        int t0;
        clear_mon();
        step(5);
        check("reset_interrupt", int'(Interrupt), 0);
        check("reset_power_level", int'(PowerButtonLevel), 0);
        check("reset_reset_level", int'(ResetButtonLevel), 0);
        check("reset_long_press", int'(PowerLongPress), 0);

        // Both pins held through reset release: deterministic 12-cycle press.
        clear_mon();
        t0 = cyc;
        PciReset = 1'b1;
        step(20);
        check("held_power_press_count", pcnt[3], 1);
        check("held_reset_press_count", pcnt[1], 1);
        check("held_power_press_latency", pfirst[3] - t0, 12);
        check("held_reset_press_latency", pfirst[1] - t0, 12);
        PowerButtonN = 1'b1;
        ResetButtonN = 1'b1;
        step(25);
        check("held_power_release_count", pcnt[2], 1);
        check("held_reset_release_count", pcnt[0], 1);

        // Clean press and release.
        clear_mon();
        t0 = cyc;
        PowerButtonN = 1'b0;
        step(40);
        check("clean_press_count", pcnt[3], 1);
        check_range("clean_press_latency", pfirst[3] - t0, 11, 15);
        check("clean_level_high", int'(PowerButtonLevel), 1);
        t0 = cyc;
        PowerButtonN = 1'b1;
        step(25);
        check("clean_release_count", pcnt[2], 1);
        check_range("clean_release_latency", pfirst[2] - t0, 11, 15);
        check("clean_level_low", int'(PowerButtonLevel), 0);

        // Glitch rejection.
        clear_mon();
        foreach (pcnt[i]) ;
        for (int g = 0; g < 3; g++) begin
            ResetButtonN = 1'b0;
            step((g == 0) ? 1 : (g == 1) ? 3 : 6);
            ResetButtonN = 1'b1;
            step(20);
        end
        check("glitch_interrupts", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
        check("glitch_level_seen", int'(lvl_hi[1]), 0);

        // Release bounce.
        clear_mon();
        ResetButtonN = 1'b0;
        step(30);
        check("bounce_press_count", pcnt[1], 1);
        lvl_lo[1] = 1'b0;
        ResetButtonN = 1'b1;
        step(5);
        ResetButtonN = 1'b0;
        step(20);
        check("bounce_no_release", pcnt[0], 0);
        check("bounce_level_held", int'(lvl_lo[1]), 0);
        ResetButtonN = 1'b1;
        step(25);
        check("bounce_final_release", pcnt[0], 1);

        // Long press.
        clear_mon();
        PowerButtonN = 1'b0;
        step(60);
        check("long_press_count", pcnt[4], LP_EN ? 1 : 0);
`ifdef BUTTON_LONG_PRESS_EN
        check("long_press_gap", pfirst[4] - pfirst[3], 40);
`endif
        PowerButtonN = 1'b1;
        step(25);
        check("long_press_no_repeat", pcnt[4], LP_EN ? 1 : 0);

        // Reset during PRESS_WAIT, then debounce restarts from zero.
        clear_mon();
        ResetButtonN = 1'b0;
        step(6);
        PciReset = 1'b0;
        step(3);
        check("midreset_outputs", int'({Interrupt, PowerButtonLevel, ResetButtonLevel, PowerLongPress}), 0);
        check("midreset_no_pulse", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
        t0 = cyc;
        PciReset = 1'b1;
        step(20);
        check("midreset_press_latency", pfirst[1] - t0, 12);
        ResetButtonN = 1'b1;
        step(25);

        // Random pins with occasional resets, checked cycle by cycle.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                PciReset = 1'b0;
                step($urandom_range(1, 4));
                PciReset = 1'b1;
            end
            PowerButtonN = 1'($urandom_range(0, 1));
            ResetButtonN = 1'($urandom_range(0, 1));
            step($urandom_range(1, 40));
        end
        PowerButtonN = 1'b1;
        ResetButtonN = 1'b1;
        step(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
